if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//   Instruction buffer between fetch (IF) and decode (ID) in the 5-stage RISC-V pipeline.
//   Decouples the instruction-memory fetch from ID stalls with a DEPTH-entry FIFO and a
//   valid/ready handshake on both sides; flushed on taken branch.
//   Presents head instruction, PC and pre-sliced opcode/funct3 to the decode-stage immediate
//   extender and control unit.
// PARAMETERS
//   DEPTH  4   number of entries; power of 2, >= 2
//   XLEN   32  PC width
// PORTS
//   clk_i         in   1        clock; all state updates on rising edge
//   rst_i         in   1        reset; synchronous, active-high
//   flush_i       in   1        discard all entries (branch taken / redirect)
//   in_valid_i    in   1        fetch presents an instruction
//   in_ready_o    out  1        queue can accept this cycle
//   in_pc_i       in   XLEN     PC of fetched instruction
//   in_instr_i    in   32       fetched instruction word
//   out_valid_o   out  1        head entry valid
//   out_ready_i   in   1        ID consumes head (low = ID stall)
//   out_pc_o      out  XLEN     head PC
//   out_instr_o   out  32       head instruction
//   out_op_o      out  7        out_instr_o[6:0]
//   out_funct3_o  out  3        out_instr_o[14:12]
//   count_o       out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//   Reset (rst_i=1 at edge): count=0, rd/wr ptr=0, out_valid_o=0, in_ready_o=1,
//     out_instr_o=NOP (32'h0000_0013), out_pc_o=0, out_op_o=7'b0010011, out_funct3_o=0.
//   push = in_valid_i & in_ready_o;  pop = out_valid_o & out_ready_i.
//   in_ready_o = (count_o != DEPTH); derived from state only, no comb path from out_ready_i.
//   out_valid_o = (count_o != 0); outputs show-ahead from head entry (no read latency).
//   Latency: push at edge N into empty queue -> out_valid_o=1 with that entry after edge N.
//   Push+pop same cycle: count unchanged, both pointers advance; allowed at any count < DEPTH.
//   Full: in_ready_o=0; a same-cycle pop does NOT enable a push (accepted next cycle).
//   Empty: out_valid_o=0, out_instr_o=NOP, out_pc_o=0; out_ready_i ignored.
//   Pointers log2(DEPTH) bits, wrap modulo DEPTH; no overflow/underflow possible.
//   Priority: rst_i > flush_i > push/pop. flush_i: same state as reset at next edge, the
//     same-cycle push is dropped, same-cycle pop is void; stored data need not be cleared.
//   Reset or flush mid-stream: no partially valid entry survives; first post-flush push
//     appears at head one cycle later.
//   Held inputs: entries never change while stored; out_* stable while out_valid_o & !out_ready_i.
// STRUCTURE
//   Shared package (riscv_pkg): NOP_INSTR=32'h0000_0013; opcode constants OP_IMM=7'b0010011,
//     OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011; funct3 F3_ADD=3'b000,
//     F3_SW=3'b010, F3_SRA=3'b101.
//   One sub-module: if_id_queue_mem (DEPTH x (XLEN+32) register array, 1 write port,
//     1 async read port at rd ptr). Pointer/count control and field slicing stay in top.
// TESTING
//   1 Reset: rst_i=1 two cycles -> out_valid_o=0, out_instr_o=32'h00000013, in_ready_o=1, count_o=0.
//   2 Stream: push addi (32'h00500093, pc 0x0) and sw (32'h00112223, pc 0x4), out_ready_i=1
//     -> each appears one cycle after push, out_op_o=7'h13 then 7'h23, count_o<=1.
//   3 Fill: out_ready_i=0, push 5 instrs -> first 4 accepted, in_ready_o=0 at count 4,
//     5th held; then one pop -> 5th accepted the following cycle, order preserved.
//   4 Flush: count_o=3, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0,
//     flushed push never appears; next push (pc 0x40) is head one cycle later.
//   5 Wrap: 3*DEPTH push/pop with random out_ready_i stalls -> output order and PCs match
//     scoreboard, no loss/duplication.
//   6 Stall hold: out_valid_o=1, out_ready_i=0 for 5 cycles -> out_pc_o/out_instr_o unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encodings used by the fetch/decode buffer and its bench
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SRA = 3'b101;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side valid/ready channels of the IF/ID buffer
interface if_id_queue_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_pc_i;
  logic [31:0]     in_instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [31:0]     out_instr_o;
  logic [6:0]      out_op_o;
  logic [2:0]      out_funct3_o;
  modport master (
    output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_op_o, out_funct3_o
  );
  modport slave (
    input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_op_o, out_funct3_o
  );
endinterface

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: entry storage, one write port and an async read port at the head
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: show-ahead FIFO between instruction fetch and decode, flushed on redirect
module if_id_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  if_id_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [XLEN+31:0] rdata;
  logic push, pop;
  // ready depends on occupancy only, so a full queue waits a cycle after a pop
  assign bus.in_ready_o = count_q != CW'(DEPTH);
  assign bus.out_valid_o = count_q != '0;
  assign push = bus.in_valid_i & bus.in_ready_o;
  assign pop = bus.out_valid_o & bus.out_ready_i;
  assign count_o = count_q;
  always_comb begin
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    count_d = (push && !pop) ? count_q + CW'(1) : (!push && pop) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
  if_id_queue_mem #(.DEPTH(DEPTH), .W(XLEN + 32)) u_mem (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wr_q),
    .wdata_i({bus.in_pc_i, bus.in_instr_i}),
    .raddr_i(rd_q),
    .rdata_o(rdata)
  );
  // empty queue presents a NOP at PC 0 so decode never sees stale data
  assign bus.out_instr_o = bus.out_valid_o ? rdata[31:0] : NOP_INSTR;
  assign bus.out_pc_o = bus.out_valid_o ? rdata[XLEN+31:32] : '0;
  assign bus.out_op_o = bus.out_instr_o[6:0];
  assign bus.out_funct3_o = bus.out_instr_o[14:12];
endmodule
